load_store_unit: RTL

- Memory-access initiator sitting between the core's execute stage and the word-addressed data memory.
- Accepts one load/store request at a time via a valid/ready handshake.
- Drives memRead/memWrite/address/writeData and consumes readData, which the memory registers one cycle after memRead.
- Adds byte/halfword support (sign/zero extension, read-modify-write for sub-word stores), misalignment detection and a single-cycle response pulse back to the core.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 37 +++
 rtl/load_store_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: RV32I funct3 codes,
// FSM state encoding and access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StRd   = 5'b00010,
    StWait = 5'b00100,
    StWr   = 5'b01000,
    StResp = 5'b10000
  } lsu_state_e;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2,
    SzNone = 2'd3
  } lsu_size_e;

  // SzNone flags funct3 codes that are never a legal load.
  function automatic lsu_size_e access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SzByte;
      F3_H, F3_HU: return SzHalf;
      F3_W:        return SzWord;
      default:     return SzNone;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational sub-word datapath: load extract/extend and store byte-merge
// into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];

    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: load_o = rdata_i;
    endcase

    merge_o = rdata_i;
    case (access_size(funct3_i))
      SzByte:  merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      SzHalf:  merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory with a
// one-cycle registered read port; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned WORDSIZE  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [WORDSIZE-1:0]  req_wdata,
  output logic                 resp_valid,
  output logic [WORDSIZE-1:0]  resp_rdata,
  output logic                 resp_err,
  output logic                 memRead,
  output logic                 memWrite,
  output logic [ADDR_BITS-1:0] address,
  output logic [WORDSIZE-1:0]  writeData,
  input  logic [WORDSIZE-1:0]  readData
);

  lsu_state_e           state_q;
  logic                 store_q;
  logic [2:0]           funct3_q;
  logic [ADDR_BITS+1:0] addr_q;
  logic [WORDSIZE-1:0]  wdata_q;
  logic [WORDSIZE-1:0]  resp_rdata_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;

  lsu_size_e            req_size;
  logic                 req_err;
  logic [WORDSIZE-1:0]  load_data;
  logic [WORDSIZE-1:0]  merge_data;

  // High byte-address bits alias onto the same memory word.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_BITS+2];

  always_comb begin
    req_size = access_size(req_funct3);
    req_err  = 1'b0;
    if (req_size == SzNone || (req_store && req_funct3[2])) req_err = 1'b1;
    if (req_size == SzHalf && req_addr[0]) req_err = 1'b1;
    if (req_size == SzWord && req_addr[1:0] != 2'b00) req_err = 1'b1;
  end

  lsu_align u_align (
    .offset_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .rdata_i  (readData),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            store_q      <= req_store;
            funct3_q     <= req_funct3;
            addr_q       <= req_addr[ADDR_BITS+1:0];
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= req_err;
            if (req_err) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
            end else if (req_store && req_size == SzWord) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: state_q <= StWait;
        StWait: begin
          if (store_q) begin
            wdata_q <= merge_data;
            state_q <= StWr;
          end else begin
            resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StWr: begin
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes are masked by reset so an abandoned write never reaches memory.
  assign memRead    = (state_q == StRd) && !reset;
  assign memWrite   = (state_q == StWr) && !reset;
  assign address    = addr_q[ADDR_BITS+1:2];
  assign writeData  = wdata_q;
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
